jt1943_rom_arb: RTL and testbench

- Shares the single graphics SDRAM read port between the four tile/sprite fetchers: char, scroll 1, scroll 2 and objects.
- Each requester presents an address and chip-select. The block caches the last word fetched per requester and sequences one SDRAM read at a time.
- Sits between the video layer modules, including the char layer's char_addr/char_data pair, and the SDRAM controller.

---
 rtl/jt1943_rom_arb.sv | 176 +++++++++++++++++
 tb/tb_jt1943_rom_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt1943_rom_arb.sv
// Graphics SDRAM read-port arbiter with a one-word cache per requester (char, scr1, scr2, obj).
// Optional macro JT1943_CHAR_PRIO_EN: char wins outright whenever pending; round-robin among 1-3.
module jt1943_rom_arb #(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic          char_cs,
  input  logic          scr1_cs,
  input  logic          scr2_cs,
  input  logic          obj_cs,
  input  logic [AW-1:0] char_addr,
  input  logic [AW-1:0] scr1_addr,
  input  logic [AW-1:0] scr2_addr,
  input  logic [AW-1:0] obj_addr,
  output logic [DW-1:0] char_data,
  output logic [DW-1:0] scr1_data,
  output logic [DW-1:0] scr2_data,
  output logic [DW-1:0] obj_data,
  output logic          char_ok,
  output logic          scr1_ok,
  output logic          scr2_ok,
  output logic          obj_ok,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [DW-1:0] sdram_dout
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    win_q, win_d;
  logic [1:0]    last_q, last_d;
  logic [AW-1:0] tag_q [4];
  logic [AW-1:0] tag_d [4];
  logic [DW-1:0] data_q [4];
  logic [DW-1:0] data_d [4];
  logic [3:0]    valid_q, valid_d;

  logic [3:0]    cs_v, ok_v, pend_v;
  logic [AW-1:0] addr_v [4];
  logic          gnt_any;
  logic [1:0]    gnt_idx, cand;

  assign cs_v = {obj_cs, scr2_cs, scr1_cs, char_cs};

  always_comb begin
    addr_v[0] = char_addr;
    addr_v[1] = scr1_addr;
    addr_v[2] = scr2_addr;
    addr_v[3] = obj_addr;
    for (int unsigned i = 0; i < 4; i++)
      ok_v[i] = cs_v[i] & valid_q[i] & (tag_q[i] == addr_v[i]) & ~downloading;
    pend_v = cs_v & ~ok_v;
  end

  // First pending index found wins; the search order starts just after last_q.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
`ifdef JT1943_CHAR_PRIO_EN
    if (pend_v[0]) begin
      gnt_any = 1'b1;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        cand = 2'(((32'(last_q) + k) % 3) + 1);
        if (!gnt_any && pend_v[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
`else
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!gnt_any && pend_v[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    win_d   = win_q;
    last_d  = last_q;
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (downloading) begin
      state_d = IDLE;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_any) begin
          win_d   = gnt_idx;
          addr_d  = addr_v[gnt_idx];
`ifdef JT1943_CHAR_PRIO_EN
          if (gnt_idx != 2'd0) last_d = gnt_idx;
`else
          last_d  = gnt_idx;
`endif
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
        WAIT_ACK: if (sdram_ack) begin
          req_d = 1'b0;
          if (sdram_rdy) begin
            data_d[win_q]  = sdram_dout;
            tag_d[win_q]   = addr_q;
            valid_d[win_q] = 1'b1;
            state_d        = IDLE;
          end else begin
            state_d = WAIT_DATA;
          end
        end
        WAIT_DATA: if (sdram_rdy) begin
          data_d[win_q]  = sdram_dout;
          tag_d[win_q]   = addr_q;
          valid_d[win_q] = 1'b1;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      win_q   <= '0;
      last_q  <= 2'd3;
      valid_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      for (int unsigned i = 0; i < 4; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign char_data  = data_q[0];
  assign scr1_data  = data_q[1];
  assign scr2_data  = data_q[2];
  assign obj_data   = data_q[3];
  assign char_ok    = ok_v[0];
  assign scr1_ok    = ok_v[1];
  assign scr2_ok    = ok_v[2];
  assign obj_ok     = ok_v[3];

endmodule

// File: tb/tb_jt1943_rom_arb.sv
// Directed bench for jt1943_rom_arb: inputs driven and outputs sampled on the falling edge.
module tb_jt1943_rom_arb;

  localparam int AW = 22;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          downloading;
  logic          char_cs, scr1_cs, scr2_cs, obj_cs;
  logic [AW-1:0] char_addr, scr1_addr, scr2_addr, obj_addr;
  logic [DW-1:0] char_data, scr1_data, scr2_data, obj_data;
  logic          char_ok, scr1_ok, scr2_ok, obj_ok;
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack, sdram_rdy;
  logic [DW-1:0] sdram_dout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [3:0]    oks;
  logic [DW-1:0] datas [4];
  logic [AW-1:0] A [4];
  logic [DW-1:0] D [4];
  int unsigned   req_cnt;

  always #5 clk = ~clk;

  jt1943_rom_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .char_cs(char_cs), .scr1_cs(scr1_cs), .scr2_cs(scr2_cs), .obj_cs(obj_cs),
    .char_addr(char_addr), .scr1_addr(scr1_addr), .scr2_addr(scr2_addr), .obj_addr(obj_addr),
    .char_data(char_data), .scr1_data(scr1_data), .scr2_data(scr2_data), .obj_data(obj_data),
    .char_ok(char_ok), .scr1_ok(scr1_ok), .scr2_ok(scr2_ok), .obj_ok(obj_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout)
  );

  always_comb begin
    oks      = {obj_ok, scr2_ok, scr1_ok, char_ok};
    datas[0] = char_data;
    datas[1] = scr1_data;
    datas[2] = scr2_data;
    datas[3] = obj_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; downloading = 1'b0;
    char_cs = 1'b0; scr1_cs = 1'b0; scr2_cs = 1'b0; obj_cs = 1'b0;
    char_addr = '0; scr1_addr = '0; scr2_addr = '0; obj_addr = '0;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for sdram_req at a falling edge.
  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (!sdram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sdram_req), 32'd1);
  endtask

  // Ack one cycle after req; rdy either with the ack or one cycle later. Returns after the capture edge.
  task automatic serve(input logic [DW-1:0] dout, input bit same);
    sdram_ack = 1'b1;
    if (same) begin sdram_rdy = 1'b1; sdram_dout = dout; end
    @(negedge clk);
    sdram_ack = 1'b0;
    if (same) sdram_rdy = 1'b0;
    else begin
      sdram_rdy = 1'b1; sdram_dout = dout;
      @(negedge clk);
      sdram_rdy = 1'b0;
    end
  endtask

  task automatic count_req(input int unsigned cycles);
    req_cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (sdram_req) req_cnt++;
    end
  endtask

  initial begin
    A[0] = 22'h000040; A[1] = 22'h001234; A[2] = 22'h02ABCD; A[3] = 22'h3F0001;
    D[0] = 16'h1001;   D[1] = 16'h2002;   D[2] = 16'h3003;   D[3] = 16'h4004;

    // Reset state and a single char fetch
    do_reset();
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_ok", 32'(oks), 32'd0);
    char_cs = 1'b1; char_addr = 22'h000123;
    @(negedge clk);
    check("t1_req_next_edge", 32'(sdram_req), 32'd1);
    check("t1_addr", 32'(sdram_addr), 32'h123);
    sdram_ack = 1'b1;
    @(negedge clk);
    check("t1_req_drop", 32'(sdram_req), 32'd0);
    check("t1_ok_before_rdy", 32'(char_ok), 32'd0);
    sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_dout = 16'hBEEF;
    @(negedge clk);
    sdram_rdy = 1'b0;
    check("t1_data", 32'(char_data), 32'hBEEF);
    check("t1_ok", 32'(char_ok), 32'd1);
    count_req(6);
    check("t1_hit_no_req", req_cnt, 32'd0);

    // Four misses from reset: round-robin 0,1,2,3
    do_reset();
    char_cs = 1'b1; scr1_cs = 1'b1; scr2_cs = 1'b1; obj_cs = 1'b1;
    char_addr = A[0]; scr1_addr = A[1]; scr2_addr = A[2]; obj_addr = A[3];
    for (int i = 0; i < 4; i++) begin
      wait_req($sformatf("t2_req%0d", i));
      check($sformatf("t2_grant%0d", i), 32'(sdram_addr), 32'(A[i]));
      serve(D[i], 1'b0);
    end
    count_req(6);
    check("t2_no_extra_req", req_cnt, 32'd0);
    check("t2_all_ok", 32'(oks), 32'hF);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_data%0d", i), 32'(datas[i]), 32'(D[i]));

`ifdef JT1943_CHAR_PRIO_EN
    // Char re-missing after each other grant keeps winning ahead of 1-3
    do_reset();
    char_cs = 1'b1; scr1_cs = 1'b1; scr2_cs = 1'b1; obj_cs = 1'b1;
    char_addr = A[0]; scr1_addr = A[1]; scr2_addr = A[2]; obj_addr = A[3];
    for (int i = 0; i < 4; i++) begin
      wait_req($sformatf("tp_char_req%0d", i));
      check($sformatf("tp_char%0d", i), 32'(sdram_addr), 32'(char_addr));
      serve(D[0], 1'b0);
      if (i < 3) begin
        wait_req($sformatf("tp_rr_req%0d", i));
        check($sformatf("tp_rr%0d", i), 32'(sdram_addr), 32'(A[i+1]));
        serve(D[i+1], 1'b0);
        char_addr = char_addr + 22'h100;
      end
    end
    count_req(6);
    check("tp_no_extra_req", req_cnt, 32'd0);
`endif

    // scr1 address moves between ack and rdy
    do_reset();
    scr1_cs = 1'b1; scr1_addr = 22'h10;
    wait_req("t3_req");
    check("t3_addr0", 32'(sdram_addr), 32'h10);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; scr1_addr = 22'h11; sdram_rdy = 1'b1; sdram_dout = 16'h1111;
    @(negedge clk);
    sdram_rdy = 1'b0;
    check("t3_ok_stale", 32'(scr1_ok), 32'd0);
    wait_req("t3_rereq");
    check("t3_addr1", 32'(sdram_addr), 32'h11);
    serve(16'h2222, 1'b0);
    check("t3_ok", 32'(scr1_ok), 32'd1);
    check("t3_data", 32'(scr1_data), 32'h2222);

    // ack and rdy together
    do_reset();
    obj_cs = 1'b1; obj_addr = 22'h3F0000;
    wait_req("t4_req");
    serve(16'h5A5A, 1'b1);
    check("t4_req_low", 32'(sdram_req), 32'd0);
    check("t4_data", 32'(obj_data), 32'h5A5A);
    check("t4_ok", 32'(obj_ok), 32'd1);

    // downloading pulse during WAIT_DATA
    do_reset();
    char_cs = 1'b1; char_addr = 22'h20;
    wait_req("t5_req_char");
    serve(16'h0A0A, 1'b0);
    check("t5_char_ok", 32'(char_ok), 32'd1);
    scr2_cs = 1'b1; scr2_addr = 22'h30;
    wait_req("t5_req_scr2");
    check("t5_addr_scr2", 32'(sdram_addr), 32'h30);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; downloading = 1'b1;
    @(negedge clk);
    check("t5_dl_req", 32'(sdram_req), 32'd0);
    check("t5_dl_ok", 32'(oks), 32'd0);
    downloading = 1'b0; sdram_rdy = 1'b1; sdram_dout = 16'hDEAD;
    @(negedge clk);
    sdram_rdy = 1'b0;
    check("t5_late_rdy_ignored", 32'(scr2_ok), 32'd0);
    check("t5_refetch_char_req", 32'(sdram_req), 32'd1);
    check("t5_refetch_char_addr", 32'(sdram_addr), 32'h20);
    serve(16'h0A0A, 1'b0);
    wait_req("t5_refetch_scr2_req");
    check("t5_refetch_scr2_addr", 32'(sdram_addr), 32'h30);
    serve(16'h0B0B, 1'b0);
    check("t5_final_ok", 32'(oks), 32'h5);
    check("t5_scr2_data", 32'(scr2_data), 32'h0B0B);

    // Asynchronous reset between edges
    do_reset();
    char_cs = 1'b1; char_addr = 22'h55;
    wait_req("t6_req_char");
    serve(16'h7777, 1'b0);
    scr1_cs = 1'b1; scr1_addr = 22'h66;
    wait_req("t6_req_scr1");
    check("t6_char_ok_pre", 32'(char_ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_req", 32'(sdram_req), 32'd0);
    check("t6_async_ok", 32'(oks), 32'd0);
    check("t6_async_addr", 32'(sdram_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
